// File: rtl/lfsr_rng_arbiter.sv
// lfsr_rng_arbiter: one Fibonacci LFSR shared by NREQ requesters via round-robin
// req/gnt arbitration. Each grant hands out exactly one word and advances the LFSR.
// Also handles seeding and reports when the sequence returns to the loaded seed.
// Optional build macro: LFSR_ARB_LOCK_EN adds a per-requester lock input for bursts.
module lfsr_rng_arbiter #(
  parameter int N = 8,
  parameter int NREQ = 4,
  parameter logic [N-1:0] SEED_DEFAULT = N'(1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            seed_load,
  input  logic [N-1:0]    seed_data,
  input  logic [NREQ-1:0] req,
`ifdef LFSR_ARB_LOCK_EN
  input  logic [NREQ-1:0] lock,
`endif
  output logic [NREQ-1:0] gnt,
  output logic [N-1:0]    rnd_data,
  output logic            rnd_valid,
  output logic            ready,
  output logic [N-1:0]    step_count,
  output logic            period_done
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW:0]   NREQ_W = (PW + 1)'(NREQ);
  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

  // Feedback tap masks; bit k set means s[k] feeds the XOR
  localparam logic [7:0] TAP8 = (N == 3) ? 8'b0000_0110 :
                                (N == 4) ? 8'b0000_1100 :
                                (N == 5) ? 8'b0001_0100 :
                                (N == 6) ? 8'b0011_0000 :
                                (N == 7) ? 8'b0110_0000 :
                                           8'b1011_1000;
  localparam logic [N-1:0] TAPS = TAP8[N-1:0];

  typedef enum logic {UNSEEDED, SERVE} state_t;

  state_t          state, state_next;
  logic [N-1:0]    lfsr, seed_reg, lfsr_next, seed_value;
  logic [PW-1:0]   rr_ptr, win_idx, grant_idx, ptr_after;
  logic [PW:0]     cand;
  logic            found, grant_any, grant_en, advance_ptr, wrap_seen;

  assign lfsr_next  = {lfsr[N-2:0], ^(lfsr & TAPS)};
  assign seed_value = (seed_data == '0) ? SEED_DEFAULT : seed_data;
  assign ptr_after  = (grant_idx == LAST_IDX) ? '0 : grant_idx + PW'(1);

`ifdef LFSR_ARB_LOCK_EN
  logic [PW-1:0] last_idx;
  logic          lock_hit;
  assign lock_hit = rnd_valid && req[last_idx] && lock[last_idx];
`endif

  // Round-robin search: first asserted request at or after rr_ptr, wrapping
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (PW + 1)'(k);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!found && req[cand[PW-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[PW-1:0];
      end
    end
  end

  // Pick the granted requester; a held lock re-grants the previous winner first
  always_comb begin
    grant_idx   = win_idx;
    grant_any   = found;
    advance_ptr = 1'b1;
`ifdef LFSR_ARB_LOCK_EN
    if (lock_hit) begin
      grant_idx   = last_idx;
      grant_any   = 1'b1;
      advance_ptr = 1'b0;
    end
`endif
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= UNSEEDED;
    else        state <= state_next;
  end

  // Next state and control outputs; seed_load always beats a grant
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    grant_en   = 1'b0;
    case (state)
      UNSEEDED: begin
        if (seed_load) state_next = SERVE;
      end
      SERVE: begin
        ready    = 1'b1;
        grant_en = !seed_load && grant_any;
      end
      default: state_next = UNSEEDED;
    endcase
  end

  // LFSR, seed, pointer and registered grant outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr        <= '0;
      seed_reg    <= '0;
      rr_ptr      <= '0;
      gnt         <= '0;
      rnd_data    <= '0;
      rnd_valid   <= 1'b0;
      step_count  <= '0;
      period_done <= 1'b0;
      wrap_seen   <= 1'b0;
`ifdef LFSR_ARB_LOCK_EN
      last_idx    <= '0;
`endif
    end else begin
      gnt         <= '0;
      rnd_valid   <= 1'b0;
      period_done <= 1'b0;
      if (seed_load) begin
        lfsr       <= seed_value;
        seed_reg   <= seed_value;
        step_count <= '0;
        wrap_seen  <= 1'b0;
      end else if (grant_en) begin
        gnt        <= NREQ'(1) << grant_idx;
        rnd_data   <= lfsr;
        rnd_valid  <= 1'b1;
        lfsr       <= lfsr_next;
        step_count <= wrap_seen ? N'(1) : step_count + N'(1);
        if (advance_ptr) rr_ptr <= ptr_after;
        if (lfsr_next == seed_reg) begin
          period_done <= 1'b1;
          wrap_seen   <= 1'b1;
        end else begin
          wrap_seen   <= 1'b0;
        end
`ifdef LFSR_ARB_LOCK_EN
        last_idx <= grant_idx;
`endif
      end
    end
  end

endmodule
